// File: rtl/simon_pkg.sv
// Shared constants and helpers for the Simon input path: button count, code width,
// button indices, and the rotating first-set-bit search used by the arbiter.
package simon_pkg;

  localparam int NUM_BTN = 5;
  localparam int CODE_W  = 3;

  // Four colour buttons plus start.
  localparam logic [CODE_W-1:0] BTN_0 = 3'd0;
  localparam logic [CODE_W-1:0] BTN_1 = 3'd1;
  localparam logic [CODE_W-1:0] BTN_2 = 3'd2;
  localparam logic [CODE_W-1:0] BTN_3 = 3'd3;
  localparam logic [CODE_W-1:0] BTN_4 = 3'd4;

  // Index of the first set bit of mask, searching upward from start with wrap.
  // Returns 0 for an empty mask; callers qualify with |mask.
  function automatic logic [CODE_W-1:0] first_set(input logic [NUM_BTN-1:0] mask,
                                                   input logic [CODE_W-1:0]  start);
    logic [CODE_W-1:0] res;
    logic              found;
    int                idx;
    res   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_BTN; k++) begin
      idx = (int'(start) + k) % NUM_BTN;
      if (!found && mask[idx]) begin
        res   = CODE_W'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, head visible with zero latency; push while full is accepted
// only when a pop happens on the same edge. clear empties it in one edge.
module sync_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/simon_input_arbiter.sv
// Serialises debounced button pulses into an ordered code stream; one grant per cycle,
// btn_valid one edge after the press lands in pending; presses wait in pending/FIFO
// under btn_ready backpressure. ARB_ROUND_ROBIN_EN selects round-robin over fixed priority.
module simon_input_arbiter
  import simon_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] pb_pulse,
  input  logic               accept_en,
  input  logic               flush,
  output logic               btn_valid,
  output logic [CODE_W-1:0]  btn_code,
  input  logic               btn_ready,
  output logic [NUM_BTN-1:0] pending,
  output logic               fifo_full,
  output logic               overflow
);

  logic [CODE_W-1:0]           ptr;
  logic [CODE_W-1:0]           gnt_idx;
  logic [NUM_BTN-1:0]          gnt_mask;
  logic [NUM_BTN-1:0]          cap_mask;
  logic                        grant;
  logic                        pop;
  logic                        can_push;
  logic                        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  assign pop      = btn_valid && btn_ready;
  assign can_push = (fifo_count < ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH)) || pop;
  assign grant    = (|pending) && can_push && !flush;
  assign gnt_idx  = first_set(pending, ptr);
  assign gnt_mask = grant ? (NUM_BTN'(1) << gnt_idx) : '0;
  assign cap_mask = accept_en ? pb_pulse : '0;

  // A fresh pulse on the granted bit re-arms it; only a hit on a still-waiting bit is a loss.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending <= (pending & ~gnt_mask) | cap_mask;
      if (|(cap_mask & pending & ~gnt_mask)) overflow <= 1'b1;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant) begin
      ptr <= (gnt_idx == BTN_4) ? BTN_0 : gnt_idx + 1'b1;
    end
  end
`else
  assign ptr = BTN_0;
`endif

  assign btn_valid = !fifo_empty;

  sync_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (grant),
    .din   (gnt_idx),
    .pop   (pop),
    .dout  (btn_code),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_simon_input_arbiter.sv
// Directed self-checking bench for simon_input_arbiter (default FIFO_DEPTH=4).
module tb_simon_input_arbiter;

  logic       clk;
  logic       rst;
  logic [4:0] pb_pulse;
  logic       accept_en;
  logic       flush;
  logic       btn_valid;
  logic [2:0] btn_code;
  logic       btn_ready;
  logic [4:0] pending;
  logic       fifo_full;
  logic       overflow;

  int total;
  int bad;

  simon_input_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .pb_pulse  (pb_pulse),
    .accept_en (accept_en),
    .flush     (flush),
    .btn_valid (btn_valid),
    .btn_code  (btn_code),
    .btn_ready (btn_ready),
    .pending   (pending),
    .fifo_full (fifo_full),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs set afterwards are sampled on the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [4:0] p);
    pb_pulse = p;
    tick();
    pb_pulse = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++;
    if ({btn_valid, btn_code, pending, fifo_full, overflow} !== 11'b0) begin
      bad++;
      $display("FAIL reset_state: got v=%b code=%0d pend=%b full=%b ovf=%b, want all zero",
               btn_valid, btn_code, pending, fifo_full, overflow);
    end
  endtask

  task automatic test_single_press();
    btn_ready = 1'b1;
    press(5'b00100);
    total++;
    if (pending !== 5'b00100 || btn_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_capture: pend=%b v=%b, want 00100 0", pending, btn_valid);
    end
    tick();
    total++;
    if (btn_valid !== 1'b1 || btn_code !== 3'd2 || pending !== 5'b0) begin
      bad++;
      $display("FAIL single_out: v=%b code=%0d pend=%b, want 1 2 00000", btn_valid, btn_code, pending);
    end
    tick();
    total++;
    if (btn_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_drain: v=%b, want 0", btn_valid);
    end
  endtask

  task automatic test_simultaneous();
    logic [2:0] exp_codes [3];
    exp_codes[0] = 3'd0;
    exp_codes[1] = 3'd1;
    exp_codes[2] = 3'd4;
    btn_ready = 1'b1;
    for (int rep = 0; rep < 2; rep++) begin
      press(5'b10011);
      for (int i = 0; i < 3; i++) begin
        tick();
        total++;
        if (btn_valid !== 1'b1 || btn_code !== exp_codes[i]) begin
          bad++;
          $display("FAIL simul_code rep%0d slot%0d: v=%b code=%0d, want 1 %0d",
                   rep, i, btn_valid, btn_code, exp_codes[i]);
        end
      end
      tick();
      total++;
      if (btn_valid !== 1'b0 || overflow !== 1'b0) begin
        bad++;
        $display("FAIL simul_drain rep%0d: v=%b ovf=%b, want 0 0", rep, btn_valid, overflow);
      end
    end
  endtask

  task automatic test_back_pressure();
    btn_ready = 1'b0;
    for (int i = 0; i < 5; i++) press(5'(1 << i));
    total++;
    if (fifo_full !== 1'b1 || pending !== 5'b10000) begin
      bad++;
      $display("FAIL bp_full: full=%b pend=%b, want 1 10000", fifo_full, pending);
    end
    tick();
    total++;
    if (btn_code !== 3'd0 || pending !== 5'b10000 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL bp_hold: code=%0d pend=%b ovf=%b, want 0 10000 0", btn_code, pending, overflow);
    end
    btn_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (btn_valid !== 1'b1 || btn_code !== 3'(i)) begin
        bad++;
        $display("FAIL bp_order slot%0d: v=%b code=%0d, want 1 %0d", i, btn_valid, btn_code, i);
      end
      tick();
    end
    total++;
    if (btn_valid !== 1'b0 || fifo_full !== 1'b0 || pending !== 5'b0) begin
      bad++;
      $display("FAIL bp_drain: v=%b full=%b pend=%b, want 0 0 00000", btn_valid, fifo_full, pending);
    end
  endtask

  task automatic test_loss_and_flush();
    btn_ready = 1'b0;
    press(5'b00001);
    press(5'b00010);
    press(5'b00100);
    press(5'b00001);
    press(5'b01000);
    total++;
    if (overflow !== 1'b0 || fifo_full !== 1'b1 || pending !== 5'b01000) begin
      bad++;
      $display("FAIL loss_pre: ovf=%b full=%b pend=%b, want 0 1 01000", overflow, fifo_full, pending);
    end
    press(5'b01000);
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL loss_set: ovf=%b, want 1", overflow);
    end
    tick();
    tick();
    tick();
    total++;
    if (overflow !== 1'b1 || pending !== 5'b01000) begin
      bad++;
      $display("FAIL loss_sticky: ovf=%b pend=%b, want 1 01000", overflow, pending);
    end
    flush    = 1'b1;
    pb_pulse = 5'b00010;
    tick();
    flush    = 1'b0;
    pb_pulse = '0;
    total++;
    if (overflow !== 1'b0 || btn_valid !== 1'b0 || pending !== 5'b0 || fifo_full !== 1'b0) begin
      bad++;
      $display("FAIL flush_clear: ovf=%b v=%b pend=%b full=%b, want 0 0 00000 0",
               overflow, btn_valid, pending, fifo_full);
    end
    tick();
    total++;
    if (btn_valid !== 1'b0 || pending !== 5'b0) begin
      bad++;
      $display("FAIL flush_discard: v=%b pend=%b, want 0 00000", btn_valid, pending);
    end
  endtask

  task automatic test_accept_disable();
    btn_ready = 1'b1;
    accept_en = 1'b0;
    press(5'b11111);
    total++;
    if (pending !== 5'b0) begin
      bad++;
      $display("FAIL accept_off_pend: pend=%b, want 00000", pending);
    end
    tick();
    total++;
    if (btn_valid !== 1'b0) begin
      bad++;
      $display("FAIL accept_off_valid: v=%b, want 0", btn_valid);
    end
    accept_en = 1'b1;
  endtask

  task automatic test_reset_midway();
    btn_ready = 1'b0;
    press(5'b01000);
    press(5'b00010);
    press(5'b00100);
    tick();
    total++;
    if (btn_valid !== 1'b1 || btn_code !== 3'd3 || pending !== 5'b0 || fifo_full !== 1'b0) begin
      bad++;
      $display("FAIL midreset_pre: v=%b code=%0d pend=%b full=%b, want 1 3 00000 0",
               btn_valid, btn_code, pending, fifo_full);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({btn_valid, btn_code, pending, fifo_full, overflow} !== 11'b0) begin
      bad++;
      $display("FAIL midreset_post: v=%b code=%0d pend=%b full=%b ovf=%b, want all zero",
               btn_valid, btn_code, pending, fifo_full, overflow);
    end
  endtask

  task automatic test_back_to_back_same_bit();
    btn_ready = 1'b1;
    press(5'b00100);
    press(5'b00100);
    total++;
    if (btn_valid !== 1'b1 || btn_code !== 3'd2 || pending !== 5'b00100 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL regrant_first: v=%b code=%0d pend=%b ovf=%b, want 1 2 00100 0",
               btn_valid, btn_code, pending, overflow);
    end
    tick();
    total++;
    if (btn_valid !== 1'b1 || btn_code !== 3'd2 || pending !== 5'b0) begin
      bad++;
      $display("FAIL regrant_second: v=%b code=%0d pend=%b, want 1 2 00000", btn_valid, btn_code, pending);
    end
    tick();
    total++;
    if (btn_valid !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL regrant_drain: v=%b ovf=%b, want 0 0", btn_valid, overflow);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    pb_pulse  = '0;
    accept_en = 1'b1;
    flush     = 1'b0;
    btn_ready = 1'b0;
    test_reset();
    test_single_press();
    test_simultaneous();
    test_back_pressure();
    test_loss_and_flush();
    test_accept_disable();
    test_reset_midway();
    test_back_to_back_same_bit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
